// File: rtl/audio_nios_lcd_pkg.sv
// Shared definitions for the Nios character-LCD bus sequencer: FSM encoding,
// Avalon address map and LCD status-register layout.
package audio_nios_lcd_pkg;

  localparam int TIMER_W    = 16;
  localparam int POLL_CNT_W = 12;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_P_SETUP = 4'd1;
  localparam logic [3:0] S_P_EH    = 4'd2;
  localparam logic [3:0] S_P_HOLD  = 4'd3;
  localparam logic [3:0] S_P_GAP   = 4'd4;
  localparam logic [3:0] S_A_SETUP = 4'd5;
  localparam logic [3:0] S_A_EH    = 4'd6;
  localparam logic [3:0] S_A_HOLD  = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;
  localparam logic [3:0] S_A_GAP   = 4'd9;

  localparam logic [1:0] ADDR_IR_WR     = 2'b00;
  localparam logic [1:0] ADDR_STATUS_RD = 2'b01;
  localparam logic [1:0] ADDR_DR_WR     = 2'b10;
  localparam logic [1:0] ADDR_DR_RD     = 2'b11;

  localparam int BUSY_BIT = 7;

  function automatic logic is_poll_bus(input logic [3:0] s);
    return (s == S_P_SETUP) || (s == S_P_EH) || (s == S_P_HOLD);
  endfunction

  function automatic logic is_access_bus(input logic [3:0] s);
    return (s == S_A_SETUP) || (s == S_A_EH) || (s == S_A_HOLD);
  endfunction

endpackage

// File: rtl/audio_nios_lcd_phase_timer.sv
// Loadable down-counter timing one bus phase; expire is high on the phase's
// last cycle.
module audio_nios_lcd_phase_timer
  import audio_nios_lcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] length,
  output logic               expire
);

  localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= length - ONE;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/audio_nios_lcd_timing_master.sv
// Avalon-MM slave that stalls the CPU while it polls the HD44780 busy flag and
// then runs one timed RS/RW/E bus cycle on the character-LCD header.
module audio_nios_lcd_timing_master
  import audio_nios_lcd_pkg::*;
#(
  parameter int T_AS         = 3,
  parameter int T_EH         = 12,
  parameter int T_AH         = 2,
  parameter int T_GAP        = 13,
  parameter bit POLL_BUSY    = 1'b1,
  parameter int BUSY_TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       busy_timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam logic [TIMER_W-1:0]    LEN_AS     = TIMER_W'(T_AS);
  localparam logic [TIMER_W-1:0]    LEN_EH     = TIMER_W'(T_EH);
  localparam logic [TIMER_W-1:0]    LEN_AH     = TIMER_W'(T_AH);
  localparam logic [TIMER_W-1:0]    LEN_GAP    = TIMER_W'(T_GAP);
  localparam logic [TIMER_W-1:0]    LEN_ONE    = TIMER_W'(1);
  localparam logic [POLL_CNT_W-1:0] POLL_LIMIT = POLL_CNT_W'(BUSY_TIMEOUT);
  localparam logic [POLL_CNT_W-1:0] POLL_ONE   = POLL_CNT_W'(1);

  logic [3:0]            state;
  logic [3:0]            next_state;
  logic [1:0]            addr_q;
  logic [7:0]            wdata_q;
  logic                  busy_q;
  logic [POLL_CNT_W-1:0] poll_count;
  logic                  drive_en;
  logic                  req;
  logic                  req_valid;
  logic                  poll_more;
  logic [1:0]            cur_addr;
  logic                  timer_load;
  logic                  expire;
  logic [TIMER_W-1:0]    phase_len;

  assign req       = read | write;
  assign req_valid = (write & ~read & ~address[0]) | (read & ~write & address[0]);
  assign poll_more = busy_q && (poll_count != POLL_LIMIT);
  // Pins for the first phase are registered on the accept edge, before addr_q exists.
  assign cur_addr  = (state == S_IDLE) ? address : addr_q;

  assign waitrequest = req & (state != S_DONE);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (!req_valid) next_state = S_DONE;
          else if (POLL_BUSY && (address != ADDR_STATUS_RD)) next_state = S_P_SETUP;
          else next_state = S_A_SETUP;
        end
      end
      S_P_SETUP: if (expire) next_state = S_P_EH;
      S_P_EH:    if (expire) next_state = S_P_HOLD;
      S_P_HOLD:  if (expire) next_state = S_P_GAP;
      S_P_GAP:   if (expire) next_state = poll_more ? S_P_SETUP : S_A_SETUP;
      S_A_SETUP: if (expire) next_state = S_A_EH;
      S_A_EH:    if (expire) next_state = S_A_HOLD;
      S_A_HOLD:  if (expire) next_state = S_DONE;
      S_DONE:    next_state = S_A_GAP;
      S_A_GAP:   if (expire) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    case (next_state)
      S_P_SETUP, S_A_SETUP: phase_len = LEN_AS;
      S_P_EH, S_A_EH:       phase_len = LEN_EH;
      S_P_HOLD, S_A_HOLD:   phase_len = LEN_AH;
      S_P_GAP, S_A_GAP:     phase_len = LEN_GAP;
      default:              phase_len = LEN_ONE;
    endcase
  end

  assign timer_load = (next_state != state);

  audio_nios_lcd_phase_timer u_phase_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .length  (phase_len),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Request capture, busy polling bookkeeping and read data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      poll_count   <= '0;
      readdata     <= '0;
      busy_timeout <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        poll_count <= '0;
        if (req) begin
          addr_q  <= address;
          wdata_q <= writedata;
          if (!req_valid) readdata <= '0;
        end
      end
      if (state == S_P_EH && expire) busy_q <= LCD_data[BUSY_BIT];
      if (state == S_P_GAP && expire && busy_q) begin
        if (poll_more) poll_count <= poll_count + POLL_ONE;
        else           busy_timeout <= 1'b1;
      end
      if (state == S_A_EH && expire && addr_q[0]) readdata <= LCD_data;
    end
  end

  // LCD pins are registered from the next state so they change with it, glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_RW   <= 1'b1;
      drive_en <= 1'b0;
    end else begin
      LCD_E    <= (next_state == S_P_EH) || (next_state == S_A_EH);
      LCD_RW   <= is_access_bus(next_state) ? cur_addr[0] : 1'b1;
      drive_en <= is_access_bus(next_state) & ~cur_addr[0];
      if (is_poll_bus(next_state))        LCD_RS <= 1'b0;
      else if (is_access_bus(next_state)) LCD_RS <= cur_addr[1];
    end
  end

  assign LCD_data = drive_en ? wdata_q : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_audio_nios_lcd_timing_master.sv
// Self-checking bench: two DUTs (no polling / polling with a short timeout)
// checked every cycle against a phase-arithmetic model of the LCD bus cycle.
module tb_audio_nios_lcd_timing_master;

  localparam int T_AS       = 3;
  localparam int T_EH       = 12;
  localparam int T_AH       = 2;
  localparam int T_GAP      = 13;
  localparam int BUS_LEN    = T_AS + T_EH + T_AH;
  localparam int POLL_LEN   = BUS_LEN + T_GAP;
  localparam int TIMEOUT1   = 4;
  localparam int WAIT_LIMIT = 600;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] address_s     [2];
  logic       read_s        [2];
  logic       write_s       [2];
  logic [7:0] writedata_s   [2];
  logic [7:0] readdata_s    [2];
  logic       waitrequest_s [2];
  logic       busy_timeout_s[2];
  logic       lcd_e         [2];
  logic       lcd_rs        [2];
  logic       lcd_rw        [2];
  wire  [7:0] lcd_data0;
  wire  [7:0] lcd_data1;

  audio_nios_lcd_timing_master #(.POLL_BUSY(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address_s[0]), .read(read_s[0]),
    .write(write_s[0]), .writedata(writedata_s[0]), .readdata(readdata_s[0]),
    .waitrequest(waitrequest_s[0]), .busy_timeout(busy_timeout_s[0]),
    .LCD_E(lcd_e[0]), .LCD_RS(lcd_rs[0]), .LCD_RW(lcd_rw[0]), .LCD_data(lcd_data0)
  );

  audio_nios_lcd_timing_master #(.POLL_BUSY(1'b1), .BUSY_TIMEOUT(TIMEOUT1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address_s[1]), .read(read_s[1]),
    .write(write_s[1]), .writedata(writedata_s[1]), .readdata(readdata_s[1]),
    .waitrequest(waitrequest_s[1]), .busy_timeout(busy_timeout_s[1]),
    .LCD_E(lcd_e[1]), .LCD_RS(lcd_rs[1]), .LCD_RW(lcd_rw[1]), .LCD_data(lcd_data1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // LCD model: status reads (E falling with RS=0, RW=1) count down the busy period.
  int stat_cnt0 = 0;
  int stat_cnt1 = 0;
  always @(negedge lcd_e[0]) if (reset_n && !lcd_rs[0] && lcd_rw[0]) stat_cnt0 = stat_cnt0 + 1;
  always @(negedge lcd_e[1]) if (reset_n && !lcd_rs[1] && lcd_rw[1]) stat_cnt1 = stat_cnt1 + 1;

  int rise_last = 0;
  int rise_prev = 0;
  always @(posedge lcd_e[0]) begin
    rise_prev = rise_last;
    rise_last = cyc;
  end

  int         busy_until[2];
  logic [7:0] dr_val;

  // While RW=1 and E is low the bench parks 8'h5A on the bus, so any DUT drive shows up as corruption.
  function automatic logic [7:0] lcd_model(input logic e, input logic rs, input logic busy, input logic [7:0] dr);
    if (!e) return 8'h5A;
    if (rs) return dr;
    return {busy, 7'h2A};
  endfunction

  assign lcd_data0 = lcd_rw[0] ? lcd_model(lcd_e[0], lcd_rs[0], stat_cnt0 < busy_until[0], dr_val) : 8'hzz;
  assign lcd_data1 = lcd_rw[1] ? lcd_model(lcd_e[1], lcd_rs[1], stat_cnt1 < busy_until[1], dr_val) : 8'hzz;

  function automatic int stat_of(input int s);
    return (s == 1) ? stat_cnt1 : stat_cnt0;
  endfunction

  logic       trk_on = 1'b0;
  int         trk_sel = 0;
  int         trk_base = 0;
  int         trk_npoll = 0;
  logic       trk_valid = 1'b0;
  logic [1:0] trk_addr = 2'b00;
  logic [7:0] trk_wdata = 8'h00;
  logic       prev_rs[2];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expected pins from phase arithmetic: k cycles after the request is first seen in IDLE.
  task automatic checkOutput();
    int k, j, m, done_k, s;
    logic e_x, rs_x, rw_x, w_x;
    logic [7:0] bus_x, bus_a;
    s = trk_sel;
    k = cyc - trk_base;
    e_x = 1'b0;
    rw_x = 1'b1;
    rs_x = prev_rs[s];
    if (k >= 1 && trk_valid) begin
      if (k < 1 + trk_npoll * POLL_LEN) begin
        j = (k - 1) % POLL_LEN;
        rs_x = 1'b0;
        e_x = (j >= T_AS) && (j < T_AS + T_EH);
      end else begin
        m = k - 1 - trk_npoll * POLL_LEN;
        rs_x = trk_addr[1];
        if (m < BUS_LEN) begin
          rw_x = trk_addr[0];
          e_x = (m >= T_AS) && (m < T_AS + T_EH);
        end
      end
    end
    done_k = trk_valid ? 1 + trk_npoll * POLL_LEN + BUS_LEN : 1;
    w_x = (k != done_k);
    bus_a = (s == 1) ? lcd_data1 : lcd_data0;
    bus_x = rw_x ? lcd_model(lcd_e[s], lcd_rs[s], stat_of(s) < busy_until[s], dr_val) : trk_wdata;
    chk("lcd_e", 32'(lcd_e[s]), 32'(e_x));
    chk("lcd_rs", 32'(lcd_rs[s]), 32'(rs_x));
    chk("lcd_rw", 32'(lcd_rw[s]), 32'(rw_x));
    chk("waitrequest", 32'(waitrequest_s[s]), 32'(w_x));
    chk("lcd_data", 32'(bus_a), 32'(bus_x));
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (trk_on) checkOutput();
    end
  endtask

  // Issue one Avalon access, hold it through waitrequest and check the DONE cycle.
  task automatic applyStimulus(input int s, input logic rd, input logic wr, input logic [1:0] a,
                               input logic [7:0] d, input int pre, input int exp_done,
                               output logic [7:0] rdata);
    logic valid;
    int rem, n, done;
    valid = (wr && !rd && !a[0]) || (rd && !wr && a[0]);
    trk_npoll = 0;
    if (s == 1 && valid && a != 2'b01) begin
      rem = busy_until[1] - stat_cnt1;
      if (rem < 0) rem = 0;
      trk_npoll = (rem > TIMEOUT1) ? TIMEOUT1 + 1 : rem + 1;
    end
    @(posedge clk);
    #1;
    address_s[s] = a;
    read_s[s] = rd;
    write_s[s] = wr;
    writedata_s[s] = d;
    trk_sel = s;
    trk_valid = valid;
    trk_addr = a;
    trk_wdata = d;
    trk_base = cyc + pre;
    trk_on = 1'b1;
    for (n = 0; n < WAIT_LIMIT; n++) begin
      @(negedge clk);
      #2;
      if (!waitrequest_s[s]) break;
    end
    done = n - pre;
    rdata = readdata_s[s];
    chk("done_cycle", 32'(done), 32'(exp_done));
    @(posedge clk);
    #1;
    read_s[s] = 1'b0;
    write_s[s] = 1'b0;
    trk_on = 1'b0;
    if (valid) prev_rs[s] = a[1];
  endtask

  task automatic idle_gap();
    repeat (T_GAP + 2) @(posedge clk);
  endtask

  initial begin
    logic [7:0] rd;
    int s0;
    for (int i = 0; i < 2; i++) begin
      address_s[i] = 2'b00;
      read_s[i] = 1'b0;
      write_s[i] = 1'b0;
      writedata_s[i] = 8'h00;
      busy_until[i] = 0;
      prev_rs[i] = 1'b0;
    end
    dr_val = 8'h41;
    fork
      compare_loop();
    join_none

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_lcd_e", 32'(lcd_e[i]), 32'd0);
      chk("reset_lcd_rs", 32'(lcd_rs[i]), 32'd0);
      chk("reset_lcd_rw", 32'(lcd_rw[i]), 32'd1);
      chk("reset_readdata", 32'(readdata_s[i]), 32'd0);
      chk("reset_busy_timeout", 32'(busy_timeout_s[i]), 32'd0);
      chk("reset_waitrequest", 32'(waitrequest_s[i]), 32'd0);
    end
    chk("reset_bus0", 32'(lcd_data0), 32'h5A);
    chk("reset_bus1", 32'(lcd_data1), 32'h5A);
    reset_n = 1'b1;
    idle_gap();

    $display("[TB] IR write 0x38, no polling");
    applyStimulus(0, 1'b0, 1'b1, 2'b00, 8'h38, 0, 18, rd);
    idle_gap();

    $display("[TB] DR read, LCD returns 0x41");
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 8'h00, 0, 18, rd);
    chk("dr_read_data", 32'(rd), 32'h41);
    idle_gap();

    $display("[TB] simultaneous read and write");
    applyStimulus(0, 1'b1, 1'b1, 2'b10, 8'hC3, 0, 1, rd);
    chk("rdwr_readdata", 32'(rd), 32'h00);
    idle_gap();

    dr_val = 8'h7E;
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 8'h00, 0, 18, rd);
    chk("dr_read_data2", 32'(rd), 32'h7E);
    idle_gap();

    $display("[TB] write to odd address");
    applyStimulus(0, 1'b0, 1'b1, 2'b01, 8'h99, 0, 1, rd);
    chk("odd_write_readdata", 32'(rd), 32'h00);
    idle_gap();

    $display("[TB] back-to-back writes");
    applyStimulus(0, 1'b0, 1'b1, 2'b10, 8'h55, 0, 18, rd);
    applyStimulus(0, 1'b0, 1'b1, 2'b00, 8'h0C, T_GAP - 1, 18, rd);
    chk("e_rise_spacing", 32'(rise_last - rise_prev), 32'd32);
    idle_gap();

    $display("[TB] status read while busy, no poll phase");
    busy_until[1] = stat_cnt1 + 1;
    applyStimulus(1, 1'b1, 1'b0, 2'b01, 8'h00, 0, 18, rd);
    chk("status_read_data", 32'(rd), 32'hAA);
    idle_gap();

    $display("[TB] busy for 3 polls then IR write 0x01");
    busy_until[1] = stat_cnt1 + 3;
    s0 = stat_cnt1;
    applyStimulus(1, 1'b0, 1'b1, 2'b00, 8'h01, 0, 138, rd);
    chk("poll_count_3busy", 32'(stat_cnt1 - s0), 32'd4);
    chk("no_timeout", 32'(busy_timeout_s[1]), 32'd0);
    idle_gap();

    $display("[TB] permanently busy, timeout after 5 polls");
    busy_until[1] = stat_cnt1 + 100000;
    s0 = stat_cnt1;
    applyStimulus(1, 1'b0, 1'b1, 2'b10, 8'h48, 0, 168, rd);
    chk("poll_count_timeout", 32'(stat_cnt1 - s0), 32'd5);
    chk("timeout_set", 32'(busy_timeout_s[1]), 32'd1);
    idle_gap();

    busy_until[1] = stat_cnt1;
    applyStimulus(1, 1'b0, 1'b1, 2'b00, 8'h06, 0, 48, rd);
    chk("timeout_sticky", 32'(busy_timeout_s[1]), 32'd1);
    idle_gap();

    $display("[TB] reset pulse during enable-high phase");
    @(posedge clk);
    #1;
    address_s[0] = 2'b00;
    writedata_s[0] = 8'h38;
    write_s[0] = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    chk("e_high_before_reset", 32'(lcd_e[0]), 32'd1);
    chk("bus_driven_before_reset", 32'(lcd_data0), 32'h38);
    reset_n = 1'b0;
    #1;
    chk("reset_e_drop", 32'(lcd_e[0]), 32'd0);
    chk("reset_rw_high", 32'(lcd_rw[0]), 32'd1);
    chk("reset_bus_released", 32'(lcd_data0), 32'h5A);
    chk("reset_clears_timeout", 32'(busy_timeout_s[1]), 32'd0);
    write_s[0] = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    prev_rs[0] = 1'b0;
    prev_rs[1] = 1'b0;
    idle_gap();

    applyStimulus(0, 1'b0, 1'b1, 2'b00, 8'h38, 0, 18, rd);
    idle_gap();
    applyStimulus(1, 1'b0, 1'b1, 2'b00, 8'h01, 0, 48, rd);
    idle_gap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
